hex_digit_sequencer: RTL and testbench
======================================

HEX_DIGIT_SEQUENCER -- requirements
Module: hex_digit_sequencer

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 4, meaning clock cycles per emission slot; legal range is 1..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: a request to begin sequencing, sampled in IDLE.
REQ-005 The block SHALL have port stop, input, 1 bit: a request to abort sequencing, returning the block to IDLE.
REQ-006 The block SHALL have port dir, input, 1 bit: step direction, 1 = up, 0 = down.
REQ-007 The block SHALL have port load, input, 1 bit: a request to load load_val, honoured in IDLE only.
REQ-008 The block SHALL have port load_val, input, 4 bits: the preset nibble.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the downstream segment decoder accepts the nibble.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the nibble on out_d1..out_d4 is valid.
REQ-011 The block SHALL have ports out_d1, out_d2, out_d3, out_d4, output, 1 bit each: the nibble, out_d1 MSB, out_d4 LSB, wired directly to decoder inputs in1..in4.

Function
REQ-012 The block SHALL implement three states: IDLE, RUN and STALL.
REQ-013 In IDLE, start=1 and stop=0 SHALL move the block to RUN on the next edge and clear the prescaler to 0.
REQ-014 In RUN, the prescaler SHALL count 0..PRESCALE-1; at terminal count it SHALL assert out_valid with the current count and move to STALL.
REQ-015 In STALL with out_ready=1 (transfer), the block SHALL deassert out_valid next cycle, step the count by dir, restart the prescaler at 0, and return to RUN.
REQ-016 In STALL with out_ready=0, out_valid and out_d1..out_d4 SHALL remain stable and the prescaler SHALL stay frozen.
REQ-017 Stepping SHALL be modulo 16: up wraps 4'hF->4'h0 and down wraps 4'h0->4'hF.
REQ-018 With PRESCALE=1, the block SHALL emit at most one value every 2 cycles: one RUN cycle, then one STALL cycle.
REQ-019 The first value emitted after start SHALL be the count held in IDLE, either the reset value or the loaded value, emitted PRESCALE cycles after RUN is entered.
REQ-020 load=1 in IDLE SHALL set the count to load_val on the next edge; load SHALL be ignored in RUN and STALL.
REQ-021 If start and load are both 1 in IDLE, the load SHALL occur and RUN SHALL be entered on the same edge, with the loaded value emitted first.
REQ-022 stop=1 in RUN or STALL SHALL return the block to IDLE on the next edge and clear out_valid, discarding a pending untransferred value without stepping.
REQ-023 stop=1 together with a transfer SHALL return the block to IDLE and still step the count.
REQ-024 start and stop both 1 in IDLE SHALL keep the block in IDLE.
REQ-025 dir SHALL be sampled only at a transfer; a change of dir while in STALL SHALL affect only the pending step.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, count 4'h0, prescaler 0, out_valid=0 and out_d1..out_d4=0.
REQ-027 Reset asserted mid-sequence SHALL abort any pending value; after release the block SHALL wait for start.
REQ-028 All flops SHALL reset asynchronously; the reset release is synchronised externally.

Configuration
REQ-029 Macro HEXSEQ_WRAP_PULSE_EN, when defined, SHALL add output port wrap_pulse (1 bit, reset 0).
REQ-030 With the macro defined, wrap_pulse SHALL be high for exactly the one cycle after a transfer whose step wrapped (F->0 up, 0->F down).
REQ-031 Without the macro, the wrap_pulse port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-032 Shared package hexseq_pkg SHALL hold the state enum (IDLE, RUN, STALL), NIBBLE_W=4, and the reset constant NIBBLE_RST=4'h0.
REQ-033 The prescaler SHALL be sub-module hexseq_prescaler, with inputs clear and enable, output tc, and parameter PRESCALE.

Verification
REQ-034 Bench: reset, start, PRESCALE=4, out_ready=1 -> out_valid at cycle 4 with 0, then 1, 2, 3 every 5 cycles.
REQ-035 Bench: load 4'hE, start, dir=1 -> emits E, F, 0, 1; with HEXSEQ_WRAP_PULSE_EN, wrap_pulse fires once after the F transfer.
REQ-036 Bench: dir=0 from 4'h1 -> emits 1, 0, F; wrap_pulse fires after the 0 transfer.
REQ-037 Bench: out_ready=0 for 10 cycles while valid -> nibble stable and no step; ready=1 -> a single transfer, then the next value after PRESCALE cycles.
REQ-038 Bench: stop in STALL holding 7 -> IDLE and valid=0 next cycle; restart emits 7 again.
REQ-039 Bench: rst_n low mid-RUN at count 9 -> outputs 0 immediately; after release there is no activity until start, and the first value emitted is 0.

Source files
------------

// File: rtl/hexseq_pkg.sv
// Shared types and constants for the hex digit sequencer: FSM state encoding,
// nibble width/reset value and the modulo-16 step helpers.
package hexseq_pkg;

  localparam int NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] NIBBLE_RST = 4'h0;
  localparam logic [NIBBLE_W-1:0] NIBBLE_ONE = 4'h1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } hexseq_state_e;

  // Modulo-16 step; the natural 4-bit overflow gives F->0 and 0->F.
  function automatic logic [NIBBLE_W-1:0] step_nibble(input logic [NIBBLE_W-1:0] v,
                                                      input logic up);
    return up ? (v + NIBBLE_ONE) : (v - NIBBLE_ONE);
  endfunction

  function automatic logic step_wraps(input logic [NIBBLE_W-1:0] v, input logic up);
    return up ? (v == {NIBBLE_W{1'b1}}) : (v == {NIBBLE_W{1'b0}});
  endfunction

endpackage

// File: rtl/hexseq_prescaler.sv
// Emission-slot prescaler: counts 0..PRESCALE-1 while enabled, tc flags the
// last cycle of a slot. clear has priority and parks the counter at 0.
module hexseq_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  assign tc = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tc ? '0 : (cnt_q + CNT_ONE);
    end
  end

endmodule

// File: rtl/hex_digit_sequencer.sv
// Steps a hex nibble up/down once per emission slot and offers it to a segment
// decoder over valid/ready. Optional wrap_pulse output: define HEXSEQ_WRAP_PULSE_EN.
module hex_digit_sequencer
  import hexseq_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                dir,
  input  logic                load,
  input  logic [NIBBLE_W-1:0] load_val,
  input  logic                out_ready,
  output logic                out_valid,
`ifdef HEXSEQ_WRAP_PULSE_EN
  output logic                wrap_pulse,
`endif
  output logic                out_d1,
  output logic                out_d2,
  output logic                out_d3,
  output logic                out_d4
);

  // Handshake: a transfer happens on a rising edge where out_valid && out_ready;
  // while out_valid is high and out_ready is low the nibble is held stable.

  hexseq_state_e       state_q, state_d;
  logic [NIBBLE_W-1:0] count_q, count_d;
  logic                valid_q, valid_d;
  logic                ps_clear;
  logic                ps_enable;
  logic                ps_tc;
  logic                transfer;

  assign transfer  = (state_q == STALL) && out_ready;
  assign ps_enable = (state_q == RUN);

  hexseq_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (ps_clear),
    .enable(ps_enable),
    .tc    (ps_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= NIBBLE_RST;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    valid_d  = valid_q;
    ps_clear = 1'b0;
    case (state_q)
      IDLE: begin
        ps_clear = 1'b1;
        valid_d  = 1'b0;
        if (load) count_d = load_val;
        if (start && !stop) state_d = RUN;
      end
      RUN: begin
        if (stop) begin
          ps_clear = 1'b1;
          state_d  = IDLE;
        end else if (ps_tc) begin
          valid_d = 1'b1;
          state_d = STALL;
        end
      end
      STALL: begin
        // A transfer always steps, even when stop arrives on the same edge.
        if (transfer) begin
          valid_d  = 1'b0;
          count_d  = step_nibble(count_q, dir);
          ps_clear = 1'b1;
          state_d  = stop ? IDLE : RUN;
        end else if (stop) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

`ifdef HEXSEQ_WRAP_PULSE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= transfer && step_wraps(count_q, dir);
    end
  end
`endif

  assign out_valid = valid_q;
  assign out_d1    = count_q[3];
  assign out_d2    = count_q[2];
  assign out_d3    = count_q[1];
  assign out_d4    = count_q[0];

endmodule

// File: tb/tb_hex_digit_sequencer.sv
// Directed bench for hex_digit_sequencer (PRESCALE=4 main instance plus a
// PRESCALE=1 instance); wrap_pulse checks are active when HEXSEQ_WRAP_PULSE_EN is set.
module tb_hex_digit_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start, stop, dir, load, out_ready;
  logic [3:0] load_val;
  logic       out_valid, out_d1, out_d2, out_d3, out_d4;
  logic       p1_valid, p1_d1, p1_d2, p1_d3, p1_d4;
  logic [3:0] nib, p1_nib;
  int         checks, errors;
`ifdef HEXSEQ_WRAP_PULSE_EN
  logic       wrap_pulse, p1_wrap;
  int         wrap_cnt;
`endif

  assign nib    = {out_d1, out_d2, out_d3, out_d4};
  assign p1_nib = {p1_d1, p1_d2, p1_d3, p1_d4};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  hex_digit_sequencer #(.PRESCALE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir),
    .load(load), .load_val(load_val), .out_ready(out_ready), .out_valid(out_valid),
`ifdef HEXSEQ_WRAP_PULSE_EN
    .wrap_pulse(wrap_pulse),
`endif
    .out_d1(out_d1), .out_d2(out_d2), .out_d3(out_d3), .out_d4(out_d4)
  );

  hex_digit_sequencer #(.PRESCALE(1)) dut_p1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir),
    .load(load), .load_val(load_val), .out_ready(out_ready), .out_valid(p1_valid),
`ifdef HEXSEQ_WRAP_PULSE_EN
    .wrap_pulse(p1_wrap),
`endif
    .out_d1(p1_d1), .out_d2(p1_d2), .out_d3(p1_d3), .out_d4(p1_d4)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_idle(input logic [3:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic start_seq(input logic with_load, input logic [3:0] v);
    load = with_load; load_val = v; start = 1'b1;
    tick();
    start = 1'b0; load = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
`ifdef HEXSEQ_WRAP_PULSE_EN
      if (wrap_pulse) wrap_cnt++;
`endif
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL wait_valid timeout: out_valid=%b after %0d cycles, required 1", out_valid, lat);
    end
  endtask

  // Runs n transfers with out_ready=1; exp_vals holds the expected nibbles MSB-first.
  task automatic run_seq(input string name, input logic [15:0] exp_vals, input int n,
                         input int exp_wraps);
    int lat;
    logic [3:0] exp;
`ifdef HEXSEQ_WRAP_PULSE_EN
    wrap_cnt = 0;
`endif
    for (int i = 0; i < n; i++) begin
      exp = exp_vals[15-4*i -: 4];
      wait_valid(lat);
      checks++;
      if (lat != 4) begin
        errors++; $display("FAIL %s latency[%0d]: got %0d, required 4", name, i, lat);
      end
      checks++;
      if (nib !== exp) begin
        errors++; $display("FAIL %s value[%0d]: got %h, required %h", name, i, nib, exp);
      end
      if (i == n - 1) stop = 1'b1;
      tick();
      stop = 1'b0;
`ifdef HEXSEQ_WRAP_PULSE_EN
      if (wrap_pulse) wrap_cnt++;
`endif
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL %s valid_drop[%0d]: got %b, required 0", name, i, out_valid);
      end
    end
`ifdef HEXSEQ_WRAP_PULSE_EN
    checks++;
    if (wrap_cnt != exp_wraps) begin
      errors++; $display("FAIL %s wrap_count: got %0d, required %0d", name, wrap_cnt, exp_wraps);
    end
`endif
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b0 || nib !== 4'h0) begin
      errors++; $display("FAIL reset_outputs: valid=%b nib=%h, required 0/0", out_valid, nib);
    end
`ifdef HEXSEQ_WRAP_PULSE_EN
    checks++;
    if (wrap_pulse !== 1'b0) begin
      errors++; $display("FAIL reset_wrap: got %b, required 0", wrap_pulse);
    end
`endif
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_count_up();
    out_ready = 1'b1; dir = 1'b1;
    start_seq(1'b0, 4'h0);
    run_seq("count_up", 16'h0123, 4, 0);
  endtask

  task automatic test_wrap_up();
    dir = 1'b1;
    load_idle(4'hE);
    start_seq(1'b0, 4'h0);
    run_seq("wrap_up", 16'hEF01, 4, 1);
  endtask

  task automatic test_wrap_down();
    dir = 1'b0;
    start_seq(1'b1, 4'h1);
    run_seq("wrap_down", 16'h10F0, 3, 1);
  endtask

  task automatic test_stall();
    int lat;
    load_idle(4'h5);
    dir = 1'b1; out_ready = 1'b0;
    start_seq(1'b0, 4'h0);
    wait_valid(lat);
    checks++;
    if (lat != 4 || nib !== 4'h5) begin
      errors++; $display("FAIL stall_first: lat=%0d nib=%h, required 4/5", lat, nib);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 5) dir = 1'b0;
      load = (i == 3); load_val = 4'hC;
      tick();
      checks++;
      if (out_valid !== 1'b1 || nib !== 4'h5) begin
        errors++; $display("FAIL stall_hold[%0d]: valid=%b nib=%h, required 1/5", i, out_valid, nib);
      end
    end
    load = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release: valid=%b, required 0", out_valid);
    end
    wait_valid(lat);
    checks++;
    if (lat != 4 || nib !== 4'h4) begin
      errors++; $display("FAIL stall_next: lat=%0d nib=%h, required 4/4", lat, nib);
    end
    out_ready = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    start_seq(1'b0, 4'h0);
    wait_valid(lat);
    checks++;
    if (nib !== 4'h4) begin
      errors++; $display("FAIL stop_no_step: nib=%h, required 4", nib);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_stop();
    int lat;
    load_idle(4'h7);
    dir = 1'b1; out_ready = 1'b0;
    start_seq(1'b0, 4'h0);
    wait_valid(lat);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stop_in_stall: valid=%b, required 0", out_valid);
    end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL start_stop_idle[%0d]: valid=%b, required 0", i, out_valid);
      end
    end
    start_seq(1'b0, 4'h0);
    load = 1'b1; load_val = 4'hA;
    wait_valid(lat);
    load = 1'b0;
    checks++;
    if (lat != 4 || nib !== 4'h7) begin
      errors++; $display("FAIL restart_value: lat=%0d nib=%h, required 4/7", lat, nib);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    load_idle(4'h9);
    out_ready = 1'b1; dir = 1'b1;
    start_seq(1'b0, 4'h0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || nib !== 4'h0) begin
      errors++; $display("FAIL reset_async: valid=%b nib=%h, required 0/0", out_valid, nib);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle[%0d]: valid=%b, required 0", i, out_valid);
      end
    end
    start_seq(1'b0, 4'h0);
    wait_valid(lat);
    checks++;
    if (lat != 4 || nib !== 4'h0) begin
      errors++; $display("FAIL post_reset_first: lat=%0d nib=%h, required 4/0", lat, nib);
    end
    stop = 1'b1; out_ready = 1'b0;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_prescale1();
    logic exp_v;
    logic [3:0] exp_n;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; out_ready = 1'b1; dir = 1'b1;
    tick();
    start_seq(1'b0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_v = (i % 2 == 0);
      exp_n = 4'(i / 2);
      checks++;
      if (p1_valid !== exp_v || (exp_v && p1_nib !== exp_n)) begin
        errors++;
        $display("FAIL prescale1[%0d]: valid=%b nib=%h, required %b/%h", i, p1_valid, p1_nib, exp_v, exp_n);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b1;
    load = 1'b0; load_val = 4'h0; out_ready = 1'b0;
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_stall();
    test_stop();
    test_reset_mid();
    test_prescale1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
